fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the program counter and drives an 8-bit, single-outstanding memory read port. It issues four byte reads per instruction and assembles them little-endian into a 32-bit word. It presents the word to decode with a valid/ready handshake and applies branch/jump redirects, including squashing of in-flight reads. It sits between the memory arbiter and the IF/ID stage and replaces the free-running PC register.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address (matches `MemAddrBus`)
RESET_PC, 32'h0, PC value loaded on reset

Ports:
clock  in  1  system clock, all state updates on its rising edge
reset  in  1  synchronous, active-high reset
mem_req_o  out  1  byte read request
mem_addr_o  out  ADDR_WIDTH  byte address of the current request
mem_gnt_i  in  1  arbiter accepts the request in this cycle
mem_rvalid_i  in  1  read data valid; earliest the cycle after grant
mem_data_i  in  8  read data byte
jump_i  in  1  redirect request from EX
jump_addr_i  in  ADDR_WIDTH  redirect target
inst_valid_o  out  1  assembled instruction available
inst_o  out  32  assembled instruction
inst_pc_o  out  ADDR_WIDTH  PC of inst_o
inst_ready_i  in  1  decode accepts (low = stall)

Behaviour:
- Reset (synchronous, active-high)
  - pc=RESET_PC, byte_cnt=0, flush=0, state=REQ.
  - mem_req_o=0, mem_addr_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0. All outputs are registered.
  - Reset has priority over every other input, including mid-read; a later mem_rvalid_i for a squashed read is ignored.
- States
  - REQ: mem_req_o=1, mem_addr_o=pc+byte_cnt. Hold until mem_gnt_i=1, then go to WAIT. Address and request stay stable while ungranted.
  - WAIT: mem_req_o=0. On mem_rvalid_i, write mem_data_i to inst_buf[8*byte_cnt+:8].
    - If byte_cnt==3: go to HOLD, byte_cnt=0.
    - Otherwise: byte_cnt+1, go to REQ.
  - HOLD: inst_valid_o=1, inst_o=inst_buf, inst_pc_o=pc. On inst_ready_i=1: pc=pc+4, go to REQ. inst_valid_o is low the next cycle.
- Timing
  - Best case per instruction (grant immediate, rvalid one cycle after grant): 2 cycles per byte, 8 cycles, then HOLD.
  - inst_valid_o rises on the 9th cycle after the first REQ.
- PC arithmetic
  - pc+4 wraps modulo 2^ADDR_WIDTH.
  - mem_addr_o=pc+byte_cnt, also modulo.
- Jump (priority below reset, above everything else)
  - Next cycle: pc={jump_addr_i[ADDR_WIDTH-1:2],2'b00} (low 2 bits ignored), byte_cnt=0, inst_valid_o=0.
  - If state was HOLD: the held instruction is discarded, even if inst_ready_i=1 in the same cycle; decode ignores fetch output in any jump cycle.
  - If state was REQ: go to REQ on the new address. A grant in the jump cycle counts as an outstanding read: set flush=1, go to WAIT.
  - If state was WAIT (read outstanding, rvalid not yet seen): set flush=1, stay in WAIT. The next mem_rvalid_i is dropped, flush clears, go to REQ at the new pc.
  - If mem_rvalid_i arrives in the jump cycle itself: that byte is dropped, no flush needed, go to REQ.
  - Back-to-back jumps: the last one wins; flush is a single bit because at most one read is outstanding.
- Stall: inst_ready_i=0 in HOLD keeps all outputs stable indefinitely. No reads are issued during stall.
- mem_rvalid_i outside WAIT with flush=0 is a protocol error and is ignored.

Decomposition:
- Shared define.v: `MemAddrBus`, `InstBus` (31:0), `ByteBus` (7:0), state encodings `FetchReq`/`FetchWait`/`FetchHold` (2-bit), `InstBytes`=4.
- One natural sub-module: inst_byte_buf. It is a 4-byte little-endian assembly register with write-enable, byte index and clear; it removes the byte-lane muxing from the FSM.

Test Plan:
- Reset, then grant=1 always, rvalid one cycle after grant, memory bytes 13,05,00,00 at addr 0..3 -> mem_addr_o sequence 0,1,2,3; inst_valid_o=1 with inst_o=32'h00000513, inst_pc_o=0 at cycle 9; next REQ address 4 after ready.
- Stall: inst_ready_i=0 for 5 cycles in HOLD -> inst_o and inst_pc_o stable, mem_req_o=0 throughout; accept -> pc=4.
- Grant delay: mem_gnt_i low 3 cycles on byte 2 -> mem_addr_o stays pc+2 and mem_req_o stays 1; assembled word is still correct.
- Jump to 32'h00000103 while in WAIT on byte 1 -> returning rvalid byte is dropped; next mem_addr_o=32'h00000100; assembled inst_pc_o=32'h100.
- Jump in HOLD with inst_ready_i=1 the same cycle -> inst_valid_o=0 next cycle, pc=jump target, old pc+4 is never fetched.
- Reset asserted in WAIT, then a stale rvalid one cycle later -> ignored; fetch restarts at RESET_PC with byte_cnt=0; PC at 32'hFFFFFFFC accepted -> wraps to 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and state encodings for the instruction-fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fetch_ctrl_pkg;

  // Number of byte reads that make up one instruction word.
  localparam int INST_BYTES = 4;

  // FSM encodings (2-bit, legacy-compatible constants).
  localparam logic [1:0] FETCH_REQ  = 2'd0;
  localparam logic [1:0] FETCH_WAIT = 2'd1;
  localparam logic [1:0] FETCH_HOLD = 2'd2;

  typedef logic [31:0] inst_t;
  typedef logic [7:0]  byte_t;
  typedef logic [1:0]  byte_idx_t;

endpackage

// File: rtl/fetch_ctrl_inst_byte_buf.sv
// Little-endian 4-byte assembly register for one instruction word.
// Latency: a write lands in the register on the next edge; word_nxt shows it this cycle.
// Backpressure: none; writes are accepted every cycle wr_en is high.
module inst_byte_buf
  import fetch_ctrl_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      clear,
  input  logic      wr_en,
  input  byte_idx_t wr_idx,
  input  byte_t     wr_data,
  output inst_t     word_nxt
);

  inst_t word;

  // Merge the pending byte into its lane; clear wins over a write.
  always_comb begin
    word_nxt = word;
    if (clear) begin
      word_nxt = '0;
    end else if (wr_en) begin
      word_nxt[{wr_idx, 3'b000} +: 8] = wr_data;
    end
  end

  // Hold the partially assembled word between byte reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      word <= '0;
    end else begin
      word <= word_nxt;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues four byte reads, presents a 32-bit word.
// Latency: 2 cycles per byte best case, word valid on the 9th cycle after the first request.
// Backpressure: inst_ready_i low holds the word and all outputs; no reads issue while held.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [7:0]            mem_data_i,
  input  logic                  jump_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  output logic                  inst_valid_o,
  output logic [31:0]           inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  input  logic                  inst_ready_i
);

  logic [1:0]            state, state_n;
  logic [ADDR_WIDTH-1:0] pc, pc_n;
  byte_idx_t             byte_cnt, cnt_n;
  logic                  flush, flush_n;
  logic                  buf_we, buf_clr;
  inst_t                 buf_word_nxt;

  logic                  granted;
  logic [ADDR_WIDTH-1:0] jump_pc;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic                  unused_jump_lsb;

  // A grant only counts while the registered request is actually up.
  assign granted  = mem_req_o & mem_gnt_i;
  // Redirect targets are word aligned; the low two bits are deliberately dropped.
  assign jump_pc  = {jump_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign unused_jump_lsb = ^jump_addr_i[1:0];
  assign pc_plus4 = pc + ADDR_WIDTH'(4);
  assign addr_n   = pc_n + {{(ADDR_WIDTH-2){1'b0}}, cnt_n};

  inst_byte_buf u_buf (
    .clock    (clock),
    .reset    (reset),
    .clear    (buf_clr),
    .wr_en    (buf_we),
    .wr_idx   (byte_cnt),
    .wr_data  (mem_data_i),
    .word_nxt (buf_word_nxt)
  );

  // Next-state logic: jump redirects take priority over the normal byte sequence.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = byte_cnt;
    flush_n = flush;
    buf_we  = 1'b0;
    buf_clr = 1'b0;

    if (jump_i) begin
      pc_n    = jump_pc;
      cnt_n   = '0;
      buf_clr = 1'b1;
      flush_n = 1'b0;
      state_n = FETCH_REQ;
      case (state)
        FETCH_REQ: begin
          // Grant in the jump cycle leaves a read in flight on the old address.
          if (granted) begin
            flush_n = 1'b1;
            state_n = FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          // Data arriving now is simply dropped; otherwise squash the next return.
          if (!mem_rvalid_i) begin
            flush_n = 1'b1;
            state_n = FETCH_WAIT;
          end
        end
        default: ;
      endcase
    end else begin
      case (state)
        FETCH_REQ: begin
          if (granted) begin
            state_n = FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (mem_rvalid_i) begin
            if (flush) begin
              flush_n = 1'b0;
              state_n = FETCH_REQ;
            end else begin
              buf_we = 1'b1;
              if (byte_cnt == byte_idx_t'(INST_BYTES - 1)) begin
                cnt_n   = '0;
                state_n = FETCH_HOLD;
              end else begin
                cnt_n   = byte_cnt + 2'd1;
                state_n = FETCH_REQ;
              end
            end
          end
        end
        FETCH_HOLD: begin
          if (inst_ready_i) begin
            pc_n    = pc_plus4;
            state_n = FETCH_REQ;
          end
        end
        default: begin
          state_n = FETCH_REQ;
        end
      endcase
    end
  end

  // State and registered outputs, all derived from the next state so they line up.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= FETCH_REQ;
      pc           <= RESET_PC;
      byte_cnt     <= '0;
      flush        <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      inst_valid_o <= 1'b0;
      inst_o       <= '0;
      inst_pc_o    <= '0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      byte_cnt     <= cnt_n;
      flush        <= flush_n;
      mem_req_o    <= (state_n == FETCH_REQ);
      mem_addr_o   <= addr_n;
      inst_valid_o <= (state_n == FETCH_HOLD);
      // Capture the word once on entry to HOLD so a stall keeps it frozen.
      if (state_n == FETCH_HOLD && state != FETCH_HOLD) begin
        inst_o    <= buf_word_nxt;
        inst_pc_o <= pc_n;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a byte-memory responder and an instruction scoreboard.
// Latency: responder returns read data rv_delay cycles after the grant cycle.
// Backpressure: grant and inst_ready_i are driven directly by the directed sequence.
module tb_fetch_ctrl;

  logic        clock;
  logic        reset;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i = 1'b0;
  logic [7:0]  mem_data_i   = 8'h00;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;
  exp_t sb_q[$];

  int          rv_delay  = 1;
  int          rv_wait   = 0;
  logic [7:0]  rv_dat    = 8'h00;
  bit          bad_fetch = 1'b0;

  fetch_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_data_i   (mem_data_i),
    .jump_i       (jump_i),
    .jump_addr_i  (jump_addr_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_ready_i (inst_ready_i)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Byte memory: first word is addi a0,x0,0 (bytes 13 05 00 00), rest is a hash of the address.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0:   mem_byte = 8'h13;
      32'h1:   mem_byte = 8'h05;
      32'h2:   mem_byte = 8'h00;
      32'h3:   mem_byte = 8'h00;
      default: mem_byte = a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    mem_word = {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  // Responder: drive rvalid just after the edge, record grants mid-cycle.
  always begin
    @(posedge clock);
    #1;
    mem_rvalid_i = 1'b0;
    if (rv_wait > 0) begin
      rv_wait = rv_wait - 1;
      if (rv_wait == 0) begin
        mem_rvalid_i = 1'b1;
        mem_data_i   = rv_dat;
      end
    end
    @(negedge clock);
    #1;
    if (mem_req_o && mem_gnt_i) begin
      rv_wait = rv_delay;
      rv_dat  = mem_byte(mem_addr_o);
      if (mem_addr_o >= 32'h108 && mem_addr_o <= 32'h10B) bad_fetch = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (inst_valid_o !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk(tag, inst_valid_o, 1);
  endtask

  task automatic wait_grant(input logic [31:0] a, input bit any, input string tag);
    int n = 0;
    while (!(mem_req_o === 1'b1 && mem_gnt_i && (any || mem_addr_o === a)) && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk(tag, mem_req_o, 1);
  endtask

  // Handshake happens in the current cycle: pop the oldest expectation and compare.
  task automatic sb_accept(input string tag);
    exp_t e;
    chk({tag, "_valid"}, inst_valid_o, 1);
    chk({tag, "_queued"}, 32'(sb_q.size() != 0), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_inst"}, inst_o, e.inst);
      chk({tag, "_pc"}, inst_pc_o, e.pc);
    end
  endtask

  initial begin
    int          first;
    int          n;
    int          ng;
    logic [31:0] addrs [4];

    reset        = 1'b1;
    mem_gnt_i    = 1'b1;
    jump_i       = 1'b0;
    jump_addr_i  = 32'h0;
    inst_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) addrs[i] = 32'hDEAD_BEEF;

    repeat (3) @(negedge clock);
    chk("rst_req",   mem_req_o,    0);
    chk("rst_addr",  mem_addr_o,   0);
    chk("rst_valid", inst_valid_o, 0);
    chk("rst_inst",  inst_o,       0);
    chk("rst_pc",    inst_pc_o,    0);
    reset = 1'b0;

    // Basic fetch from RESET_PC with immediate grant and 1-cycle data.
    sb_q.push_back('{inst: 32'h0000_0513, pc: 32'h0});
    first = -1;
    n     = 0;
    ng    = 0;
    while (inst_valid_o !== 1'b1 && n < 30) begin
      @(negedge clock);
      n++;
      if (mem_req_o && first < 0) first = n;
      if (mem_req_o && mem_gnt_i) begin
        if (ng < 4) addrs[ng] = mem_addr_o;
        ng++;
      end
    end
    chk("t1_valid_seen", inst_valid_o, 1);
    chk("t1_num_reads", ng, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_addr%0d", i), addrs[i], i);
    chk("t1_latency", n - first, 8);

    // Stall in HOLD: everything frozen, no requests.
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_valid", i), inst_valid_o, 1);
      chk($sformatf("stall%0d_inst", i),  inst_o,       32'h0000_0513);
      chk($sformatf("stall%0d_pc", i),    inst_pc_o,    0);
      chk($sformatf("stall%0d_req", i),   mem_req_o,    0);
      @(negedge clock);
    end
    inst_ready_i = 1'b1;
    sb_accept("t1_acc");
    @(negedge clock);
    chk("t1_post_valid", inst_valid_o, 0);
    chk("t1_post_req",   mem_req_o,    1);
    chk("t1_post_addr",  mem_addr_o,   32'h4);

    // Grant withheld for three cycles on byte 2 of the word at 4.
    sb_q.push_back('{inst: mem_word(32'h4), pc: 32'h4});
    wait_grant(32'h5, 1'b0, "t2_grant5");
    @(negedge clock);
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("t2_hold%0d_req", i),  mem_req_o,  1);
      chk($sformatf("t2_hold%0d_addr", i), mem_addr_o, 32'h6);
    end
    @(negedge clock);
    chk("t2_hold3_addr", mem_addr_o, 32'h6);
    mem_gnt_i = 1'b1;
    wait_valid("t2_valid");
    sb_accept("t2_acc");
    @(negedge clock);

    // Jump while waiting on byte 1: the late byte is squashed.
    rv_delay = 2;
    wait_grant(32'h9, 1'b0, "t3_grant9");
    @(negedge clock);
    jump_i      = 1'b1;
    jump_addr_i = 32'h0000_0103;
    @(negedge clock);
    jump_i = 1'b0;
    chk("t3_flush_req",   mem_req_o,    0);
    chk("t3_flush_valid", inst_valid_o, 0);
    @(negedge clock);
    chk("t3_new_req",  mem_req_o,  1);
    chk("t3_new_addr", mem_addr_o, 32'h100);
    sb_q.push_back('{inst: mem_word(32'h100), pc: 32'h100});
    rv_delay = 1;
    wait_valid("t3_valid");
    sb_accept("t3_acc");
    @(negedge clock);

    // Jump in HOLD with ready high in the same cycle: held word is discarded.
    inst_ready_i = 1'b0;
    wait_valid("t4_valid_hold");
    chk("t4_hold_pc", inst_pc_o, 32'h104);
    inst_ready_i = 1'b1;
    jump_i       = 1'b1;
    jump_addr_i  = 32'h0000_0200;
    @(negedge clock);
    jump_i = 1'b0;
    chk("t4_valid_drop", inst_valid_o, 0);
    chk("t4_req",        mem_req_o,    1);
    chk("t4_addr",       mem_addr_o,   32'h200);
    sb_q.push_back('{inst: mem_word(32'h200), pc: 32'h200});
    wait_valid("t4_valid");
    sb_accept("t4_acc");
    @(negedge clock);

    // Reset during WAIT, stale data arrives the cycle after reset.
    rv_delay = 2;
    wait_grant(32'h0, 1'b1, "t5_grant");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("t5_rst_req",   mem_req_o,    0);
    chk("t5_rst_valid", inst_valid_o, 0);
    chk("t5_rst_addr",  mem_addr_o,   0);
    chk("t5_rst_inst",  inst_o,       0);
    @(negedge clock);
    chk("t5_restart_req",  mem_req_o,  1);
    chk("t5_restart_addr", mem_addr_o, 0);
    sb_q.push_back('{inst: 32'h0000_0513, pc: 32'h0});
    wait_valid("t5_valid");
    sb_accept("t5_acc");
    @(negedge clock);

    // Jump in REQ with a grant in the same cycle, to the top word; then PC wraps.
    jump_i      = 1'b1;
    jump_addr_i = 32'hFFFF_FFFE;
    @(negedge clock);
    jump_i = 1'b0;
    chk("t6_flush_req", mem_req_o, 0);
    sb_q.push_back('{inst: mem_word(32'hFFFF_FFFC), pc: 32'hFFFF_FFFC});
    wait_valid("t6_valid");
    sb_accept("t6_acc");
    @(negedge clock);
    chk("t6_wrap_req",  mem_req_o,  1);
    chk("t6_wrap_addr", mem_addr_o, 0);

    chk("no_fetch_108", 32'(bad_fetch), 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
